// File: rtl/cache_refill.sv
// Block-refill engine: fetches every word of a missing cache block over a
// req/ack memory handshake and writes each word into the cache data array,
// then pulses done to advance the cache controller.
module cache_refill #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WORDS_LOG2 = 2,
  parameter int unsigned BYTE_OFF   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     blk_addr,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  wr_en,
  output logic [WORDS_LOG2-1:0] wr_word,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned OFF_W = WORDS_LOG2 + BYTE_OFF;
  // Clears the word and byte offset fields so base is block-aligned.
  localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [WORDS_LOG2-1:0] LAST_WORD = {WORDS_LOG2{1'b1}};

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StWrite = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [WORDS_LOG2-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [DATA_W-1:0]     data_q, data_d;

  // State, counter, latched base and captured word registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      base_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic; start and mem_ack are only looked at in the states that own them.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d  = blk_addr & BASE_MASK;
          cnt_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (cnt_q == LAST_WORD) begin
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = StReq;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded purely from registered state, so nothing follows mem_ack or start directly.
  always_comb begin
    mem_req  = (state_q == StReq);
    mem_addr = '0;
    if (state_q == StReq) begin
      mem_addr = base_q + (ADDR_W'(cnt_q) << BYTE_OFF);
    end
    wr_en   = (state_q == StWrite);
    wr_word = cnt_q;
    wr_data = data_q;
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
  end

endmodule

// File: tb/tb_cache_refill.sv
// Directed self-checking bench for cache_refill with a cycle-stepped memory responder.
module tb_cache_refill;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] blk_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wr_en;
  logic [1:0]  wr_word;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  cache_refill #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .WORDS_LOG2(2),
    .BYTE_OFF  (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .blk_addr (blk_addr),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .wr_en    (wr_en),
    .wr_word  (wr_word),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, " mem_addr"}, mem_addr, 32'd0);
    check({tag, " wr_en"}, {31'd0, wr_en}, 32'd0);
    check({tag, " wr_word"}, {30'd0, wr_word}, 32'd0);
    check({tag, " wr_data"}, wr_data, 32'd0);
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
    check({tag, " done"}, {31'd0, done}, 32'd0);
  endtask

  // Runs one refill from IDLE. Cycle 1 is the first cycle after the edge that samples start.
  // wait_word gets wait_n cycles of withheld ack; spurious acks in WRITE and moves blk_addr.
  task automatic do_refill(input logic [31:0] addr, input logic [31:0] exp_base,
                           input logic [31:0] dbase, input int wait_word, input int wait_n,
                           input int exp_done_cyc, input bit spurious, input bit hold_start);
    int cyc;
    int nw;
    int waits;
    int req_cycles;
    bit seen_done;
    cyc = 1;
    nw = 0;
    waits = 0;
    req_cycles = 0;
    seen_done = 0;
    blk_addr = addr;
    start = 1'b1;
    tick();
    start = hold_start;
    if (spurious) blk_addr = 32'hFFFF_0000;
    check("busy after start", {31'd0, busy}, 32'd1);
    while (!seen_done && cyc <= 40) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        check("mem_addr", mem_addr, exp_base + 32'(nw * 4));
        if (nw == wait_word) req_cycles++;
        if (nw == wait_word && waits < wait_n) begin
          waits++;
        end else begin
          mem_ack   = 1'b1;
          mem_rdata = dbase + 32'(nw);
        end
      end
      if (wr_en) begin
        check("wr_word", {30'd0, wr_word}, 32'(nw));
        check("wr_data", wr_data, dbase + 32'(nw));
        check("req off in write", {31'd0, mem_req}, 32'd0);
        nw++;
        if (spurious) begin
          mem_ack   = 1'b1;
          mem_rdata = 32'hDEAD_BEEF;
        end
      end
      if (done) begin
        seen_done = 1;
        check("done cycle", 32'(cyc), 32'(exp_done_cyc));
        check("writes at done", 32'(nw), 32'd4);
        if (wait_word >= 0) check("req hold cycles", 32'(req_cycles), 32'(wait_n + 1));
      end else begin
        tick();
        cyc++;
      end
    end
    if (!seen_done) check("done timeout", 32'(cyc), 32'(exp_done_cyc));
    mem_ack = 1'b0;
    tick();
    check("done single pulse", {31'd0, done}, 32'd0);
    check("busy low after done", {31'd0, busy}, 32'd0);
    check("no write after done", {31'd0, wr_en}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    blk_addr  = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    #2;
    check_all_zero("reset");
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("idle after reset", {31'd0, busy}, 32'd0);

    // Stray acks in IDLE must not write or leave IDLE.
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_5555;
    tick();
    check("idle ack wr_en", {31'd0, wr_en}, 32'd0);
    check("idle ack busy", {31'd0, busy}, 32'd0);
    tick();
    check("idle ack wr_en 2", {31'd0, wr_en}, 32'd0);
    mem_ack = 1'b0;

    // Basic refill, immediate acks.
    do_refill(32'h0000_1234, 32'h0000_1230, 32'hA0, -1, 0, 9, 1'b0, 1'b0);

    // Three wait cycles on word 2.
    do_refill(32'h0000_1234, 32'h0000_1230, 32'hA0, 2, 3, 12, 1'b0, 1'b0);

    // Spurious acks in WRITE and blk_addr moved after start.
    do_refill(32'h0000_1234, 32'h0000_1230, 32'hB0, -1, 0, 9, 1'b1, 1'b0);
    blk_addr = 32'h0000_1234;

    // Reset during the request for word 1.
    start = 1'b1;
    tick();
    start = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hC0;
    tick();
    mem_ack = 1'b0;
    check("pre-reset write", {31'd0, wr_en}, 32'd1);
    tick();
    check("pre-reset req", {31'd0, mem_req}, 32'd1);
    check("pre-reset addr", mem_addr, 32'h0000_1234);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("mid reset");
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no done after reset", {31'd0, done}, 32'd0);
      check("idle after reset", {31'd0, busy}, 32'd0);
    end
    do_refill(32'h0000_0040, 32'h0000_0040, 32'hD0, -1, 0, 9, 1'b0, 1'b0);

    // Back-to-back: start held through DONE; second refill begins from the one IDLE cycle.
    do_refill(32'h0000_1234, 32'h0000_1230, 32'hE0, -1, 0, 9, 1'b0, 1'b1);
    do_refill(32'h0000_2000, 32'h0000_2000, 32'hF0, -1, 0, 9, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_refill.md
Name: cache_refill

Overview:
- Block-refill engine directly downstream of the cache controller FSM.
- While the controller sits in its block-read state, it fetches every word of the missing block from main memory over a req/ack handshake and writes each word into the cache data array.
- Pulses `done`, which drives the controller's END input so the controller advances to its tag-update state.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width; one word per memory transfer.
- WORDS_LOG2, 2, log2 of words per block (default 4 words).
- BYTE_OFF, 2, log2 of bytes per word; equals log2(DATA_W/8).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  refill request level from the controller, high during block-read state; sampled only in IDLE.
- blk_addr  in  ADDR_W  miss byte address; low WORDS_LOG2+BYTE_OFF bits ignored.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  memory word byte address.
- mem_ack  in  1  memory read data valid and request accepted.
- mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1.
- wr_en  out  1  data-array write strobe.
- wr_word  out  WORDS_LOG2  word index within the block.
- wr_data  out  DATA_W  word to write.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle refill-complete pulse; drives the controller's END.

Behaviour:
- Reset (asynchronous, immediate on reset=1):
  - state=IDLE, cnt=0, base=0, data register=0.
  - mem_req=0, mem_addr=0, wr_en=0, wr_word=0, wr_data=0, busy=0, done=0.
- All outputs are registered or decoded from registered state; none depends combinationally on mem_ack or start.
- States: IDLE, REQ, WRITE, DONE.
- IDLE:
  - If start=1: latch base = blk_addr with low WORDS_LOG2+BYTE_OFF bits cleared, cnt=0, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - mem_req=1; mem_addr = base + (cnt << BYTE_OFF).
  - mem_req and mem_addr are held stable until mem_ack=1.
  - On mem_ack=1: capture mem_rdata, go to WRITE. Otherwise stay in REQ; wait is unbounded, no timeout.
- WRITE:
  - wr_en=1 for exactly this one cycle; wr_word=cnt; wr_data=captured word; mem_req=0.
  - If cnt equals 2^WORDS_LOG2-1: go to DONE.
  - Otherwise cnt=cnt+1, go to REQ.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - busy falls on entry to IDLE.
- Counter: WORDS_LOG2 bits; never wraps inside a refill; cleared at each start.
- Address arithmetic: modulo 2^ADDR_W. base is block-aligned, so no carry out of the offset field.
- Latency with mem_ack returned in the first REQ cycle: done is high on the (2*2^WORDS_LOG2 + 1)th edge after start is sampled, i.e. 9 cycles for 4 words.
- Each additional wait cycle in REQ adds exactly one cycle.
- Boundary conditions:
  - start is ignored outside IDLE, including a start still high during DONE.
  - start held high after returning to IDLE begins a new refill.
  - mem_ack outside REQ is ignored; no write, no state change.
  - blk_addr changes after IDLE are ignored; base is latched.
  - reset mid-refill drops mem_req immediately and abandons the outstanding request; memory must tolerate request withdrawal.
  - No partial done is ever issued after reset.
- Exactly 2^WORDS_LOG2 wr_en pulses per refill, with wr_word strictly ascending 0..2^WORDS_LOG2-1.

Test Plan:
- Reset values: assert reset mid-cycle -> all outputs 0 immediately without waiting for a clk edge; state IDLE after release.
- Basic refill:
  - Stimulus: blk_addr=0x00001234, start=1, memory acks immediately with data 0xA0..0xA3.
  - Required: mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C.
  - Required: wr_en pulses with wr_word 0..3 and wr_data 0xA0..0xA3.
  - Required: done is a single-cycle pulse 9 cycles after start is sampled.
- Wait states: memory delays ack 3 cycles on word 2 -> mem_req and mem_addr=0x1238 held stable for 4 cycles; done at cycle 12; write order unchanged.
- Spurious inputs: mem_ack=1 in IDLE and in WRITE -> no wr_en, no state change. Change blk_addr to 0xFFFF0000 mid-refill -> addresses still 0x123x.
- Reset mid-operation: reset asserted during REQ for word 1 -> mem_req drops immediately; no done is issued. A new start at blk_addr=0x40 then fetches 0x40..0x4C cleanly.
- Back-to-back: start held high through DONE -> start ignored in the DONE cycle. Second refill begins on the IDLE cycle; busy is low for exactly one cycle between refills.
